// File: rtl/rand_seq_gen_if.sv
// Control/result bundle between the sequencing FSM (master) and rand_seq_gen (slave).
// Optional hist bus exists only when RAND_SEQ_HIST_EN is defined.
interface rand_seq_gen_if #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 9,
  parameter int LFSR_W  = 16
`ifdef RAND_SEQ_HIST_EN
  , parameter int HIST_W = 6
`endif
);
  logic                     start;
  logic                     seed_load;
  logic [LFSR_W-1:0]        seed;
  logic                     busy;
  logic                     done;
  logic                     seq_valid;
  logic [SEQ_LEN*SYM_W-1:0] seq_out;
`ifdef RAND_SEQ_HIST_EN
  logic [HIST_W-1:0]        hist;
`endif

  modport master (
    output start, seed_load, seed,
    input  busy, done, seq_valid, seq_out
`ifdef RAND_SEQ_HIST_EN
    , input hist
`endif
  );

  modport slave (
    input  start, seed_load, seed,
    output busy, done, seq_valid, seq_out
`ifdef RAND_SEQ_HIST_EN
    , output hist
`endif
  );
endinterface

// File: rtl/rand_seq_gen.sv
// Constrained-random symbol sequence generator: LFSR symbols, per-symbol repeat cap.
// Define RAND_SEQ_HIST_EN to expose the live per-symbol counts on bus.hist.
module rand_seq_gen #(
  parameter int                SYM_W    = 2,
  parameter int                NUM_SYM  = 3,
  parameter int                SEQ_LEN  = 9,
  parameter int                MAX_REP  = 3,
  parameter int                STEP_DIV = 3,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED_DEF = LFSR_W'('hACE1)
) (
  input  logic          clk,
  input  logic          reset,
  rand_seq_gen_if.slave bus
);
  localparam int CW    = $clog2(MAX_REP + 1);
  localparam int IW    = $clog2(SEQ_LEN + 1);
  localparam int SW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SEQ_W = SEQ_LEN * SYM_W;

  if (NUM_SYM < 2 || NUM_SYM > 2**SYM_W) begin : g_bad_num_sym
    $error("rand_seq_gen: NUM_SYM must be in 2..2**SYM_W");
  end
  if (SEQ_LEN < 1 || SEQ_LEN > NUM_SYM * MAX_REP) begin : g_bad_seq_len
    $error("rand_seq_gen: SEQ_LEN must be in 1..NUM_SYM*MAX_REP");
  end
  if (MAX_REP < 1 || STEP_DIV < 1) begin : g_bad_rep_div
    $error("rand_seq_gen: MAX_REP and STEP_DIV must be >= 1");
  end
  if (LFSR_W < 6 || SEED_DEF == '0) begin : g_bad_lfsr
    $error("rand_seq_gen: LFSR_W must be >= 6 and SEED_DEF non-zero");
  end

  typedef enum logic {IDLE, GEN} state_e;

  state_e                     state_q, state_d;
  logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
  logic [SYM_W-1:0]           rr_q, rr_d;
  logic [SW-1:0]              step_q, step_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_SYM-1:0][CW-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0]           seq_q, seq_d;
  logic                       done_q, done_d;
  logic                       valid_q, valid_d;

  logic                       fb;
  logic [SYM_W-1:0]           raw, cand, sym;

  // x^16+x^14+x^13+x^11, taps anchored to the MSB
  assign fb   = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-3] ^ lfsr_q[LFSR_W-4] ^ lfsr_q[LFSR_W-6];
  assign raw  = lfsr_q[SYM_W-1:0];
  assign cand = (int'(raw) >= NUM_SYM) ? rr_q : raw;

  // Saturated candidate: walk forward (mod NUM_SYM) to the first symbol with room left
  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    sym   = cand;
    if (cnt_q[cand] == CW'(MAX_REP)) begin
      for (int k = 1; k < NUM_SYM; k++) begin
        j = int'(cand) + k;
        if (j >= NUM_SYM) j = j - NUM_SYM;
        if (!found && cnt_q[j] < CW'(MAX_REP)) begin
          sym   = SYM_W'(j);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[LFSR_W-2:0], fb};
    rr_d    = (rr_q == SYM_W'(NUM_SYM - 1)) ? '0 : rr_q + 1'b1;
    step_d  = step_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    if (state_q == IDLE && bus.seed_load)
      lfsr_d = (bus.seed == '0) ? SEED_DEF : bus.seed;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = GEN;
          step_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          seq_d   = '0;
          valid_d = 1'b0;
        end
      end
      GEN: begin
        if (step_q == SW'(STEP_DIV - 1)) begin
          step_d                              = '0;
          seq_d[int'(idx_q)*SYM_W +: SYM_W]   = sym;
          cnt_d[sym]                          = cnt_q[sym] + 1'b1;
          if (idx_q == IW'(SEQ_LEN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_DEF;
      rr_q    <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rr_q    <= rr_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy      = (state_q == GEN);
  assign bus.done      = done_q;
  assign bus.seq_valid = valid_q;
  assign bus.seq_out   = seq_q;
`ifdef RAND_SEQ_HIST_EN
  assign bus.hist      = cnt_q;
`endif

endmodule
